// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch/decode bundle type and reset PC default
package if_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] inst;
  } if_stage_out_t;
endpackage

// File: rtl/if_stage_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, push/pop at any occupancy
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with credit-limited requests, fetch FIFO and redirect flush
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [DATA_WIDTH-1:0]     imem_req_addr,
  input  logic                      imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     imem_rsp_data,
  input  logic                      redirect_valid,
  input  logic [DATA_WIDTH-1:0]     redirect_pc,
  output logic [3*DATA_WIDTH-1:0]   if_stage_out,
  output logic                      out_valid,
  input  logic                      out_ready
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  logic [DATA_WIDTH-1:0] pc, rsp_pc, target;
  logic [CW-1:0] outstanding, drop_cnt, fifo_count;
  logic [CW:0] credit_used;
  logic fifo_full, fifo_empty, req_fire, push, pop;
  // a slot is reserved for every in-flight request, so responses always fit
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !redirect_valid && credit_used < (CW+1)'(FIFO_DEPTH);
  assign imem_req_addr = rst ? RESET_PC : pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign push = imem_rsp_valid && drop_cnt == '0;
  assign out_valid = !rst && !fifo_empty;
  assign pop = out_valid && out_ready;
  assign target = redirect_pc & ~DATA_WIDTH'(3);
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc <= target;
      rsp_pc <= target;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop_cnt <= outstanding - CW'(imem_rsp_valid);
    end else begin
      pc <= req_fire ? pc + DATA_WIDTH'(4) : pc;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      drop_cnt <= (imem_rsp_valid && drop_cnt != '0) ? drop_cnt - CW'(1) : drop_cnt;
      rsp_pc <= push ? rsp_pc + DATA_WIDTH'(4) : rsp_pc;
    end
  end
  fetch_fifo #(.WIDTH(3*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   ({rsp_pc, rsp_pc + DATA_WIDTH'(4), imem_rsp_data}),
    .dout  (if_stage_out),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!imem_rsp_valid || outstanding != '0);
      assert (!push || !fifo_full);
      assert (imem_req_addr[1:0] == 2'b00);
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized checks of if_stage against a sequential-stream fetch model
module tb_if_stage;
  import if_stage_pkg::*;
  logic clk = 0, rst = 1;
  logic imem_req_valid, imem_req_ready = 0;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic [95:0] if_stage_out;
  logic out_valid, out_ready = 0;
  if_stage_out_t o;
  assign o = if_stage_out;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_stage_out(if_stage_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {logic [31:0] addr; int due;} req_t;
  req_t pending[$];
  int cyc = 0, last_due = 0, lat_min = 1, lat_max = 1, npop = 0, errors = 0, checks = 0;
  logic [31:0] req_pc = 0, exp_pc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock: drive inputs at negedge, check outputs, advance memory and stream models.
  task automatic cycle(input bit rdy, input bit ordy, input bit redir, input logic [31:0] rpc);
    int due;
    imem_req_ready = rdy;
    out_ready = ordy;
    redirect_valid = redir;
    redirect_pc = rpc;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      imem_rsp_valid = 1;
      imem_rsp_data = mem_word(pending[0].addr);
      void'(pending.pop_front());
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data = $urandom;
    end
    #1;
    if (out_valid) begin
      checks++;
      if (o.pc !== exp_pc || o.pc4 !== exp_pc + 32'd4 || o.inst !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL head: got pc=%h pc4=%h inst=%h, want pc=%h pc4=%h inst=%h",
                 o.pc, o.pc4, o.inst, exp_pc, exp_pc + 32'd4, mem_word(exp_pc));
      end
    end
    if (imem_req_valid) begin
      checks++;
      if (imem_req_addr !== req_pc) begin
        errors++;
        $display("FAIL req_addr: got %h want %h", imem_req_addr, req_pc);
      end
    end
    if (redir) begin
      checks++;
      if (imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL req_during_redirect: got %b want 0", imem_req_valid);
      end
    end
    if (imem_req_valid && rdy) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      pending.push_back('{req_pc, due});
      last_due = due;
      req_pc += 32'd4;
    end
    if (out_valid && ordy && !redir) begin
      exp_pc += 32'd4;
      npop++;
    end
    if (redir) begin
      req_pc = rpc & ~32'd3;
      exp_pc = req_pc;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1;
    pending.delete();
    last_due = cyc;
    req_pc = 0;
    exp_pc = 0;
    cycle(1, 1, 0, 0);
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL in_reset: got out_valid=%b req_valid=%b addr=%h want 0 0 0", out_valid, imem_req_valid, imem_req_addr);
    end
    rst = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL after_reset: got out_valid=%b req_valid=%b addr=%h want 0 1 0", out_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_reset();
    reset_dut();
  endtask

  task automatic test_stream();
    int start;
    reset_dut();
    lat_min = 1; lat_max = 1;
    start = npop;
    repeat (30) cycle(1, 1, 0, 0);
    checks++;
    if (npop - start < 15) begin
      errors++;
      $display("FAIL stream_rate: got %0d pops want >= 15", npop - start);
    end
  endtask

  task automatic test_hold();
    int start;
    reset_dut();
    lat_min = 1; lat_max = 1;
    start = npop;
    repeat (10) cycle(1, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || imem_req_valid !== 1'b0 || npop != start) begin
      errors++;
      $display("FAIL hold: got out_valid=%b req_valid=%b pops=%0d want 1 0 0", out_valid, imem_req_valid, npop - start);
    end
    repeat (20) cycle(1, 1, 0, 0);
    checks++;
    if (npop - start < 10) begin
      errors++;
      $display("FAIL hold_resume: got %0d pops want >= 10", npop - start);
    end
  endtask

  task automatic test_redirect();
    int start, n;
    reset_dut();
    lat_min = 3; lat_max = 3;
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL credit_limit: got req_valid=%b want 0", imem_req_valid);
    end
    cycle(1, 1, 1, 32'h103);
    start = npop;
    n = 0;
    while (npop == start && n < 20) begin
      cycle(1, 1, 0, 0);
      n++;
    end
    checks++;
    if (npop == start || exp_pc !== 32'h104) begin
      errors++;
      $display("FAIL redirect_first: got pops=%0d next_pc=%h want >=1 104", npop - start, exp_pc);
    end
  endtask

  task automatic test_redirect_same_cycle();
    bit found = 0;
    reset_dut();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid && pending.size() > 0 && pending[0].due <= cyc) begin
        cycle(1, 1, 1, 32'h40);
        found = 1;
      end else cycle(1, 1, 0, 0);
    end
    checks++;
    if (!found || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_same: got found=%b out_valid=%b want 1 0", found, out_valid);
    end
    repeat (10) cycle(1, 1, 0, 0);
    checks++;
    if (exp_pc == 32'h40) begin
      errors++;
      $display("FAIL redirect_same_resume: got next_pc=%h want past 40", exp_pc);
    end
  endtask

  task automatic test_random();
    int start, n;
    bit redir;
    reset_dut();
    lat_min = 1; lat_max = 4;
    start = npop;
    n = 0;
    while (npop - start < 1000 && n < 20000) begin
      redir = $urandom_range(0, 199) == 0;
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), redir, $urandom);
      n++;
    end
    checks++;
    if (npop - start < 1000) begin
      errors++;
      $display("FAIL random_progress: got %0d pops want 1000", npop - start);
    end
  endtask

  task automatic test_reset_mid();
    int start;
    reset_dut();
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 30; i++) begin
      cycle(1, 1, 0, 0);
      if (i >= 4 && pending.size() == 1) break;
    end
    reset_dut();
    start = npop;
    repeat (15) cycle(1, 1, 0, 0);
    checks++;
    if (npop - start < 5) begin
      errors++;
      $display("FAIL reset_restart: got %0d pops want >= 5", npop - start);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_hold();
    test_redirect();
    test_redirect_same_cycle();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
